// File: rtl/inv_addkey_mixcol_stage.sv
// AES decryption round stage: AddRoundKey on accept, then column-serial InvMixColumns.
// COLS_PER_CYCLE columns are transformed per cycle; the final round skips the mix.
module mix_column_helper (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    // Row 0 is the MSB byte of the column.
    for (genvar r = 0; r < 4; r++) begin : g_byte
        assign a[r]  = col_in[31 - 8*r -: 8];
        assign x2[r] = xt(a[r]);
        assign x4[r] = xt(x2[r]);
        assign x8[r] = xt(x4[r]);
        assign m9[r] = x8[r] ^ a[r];
        assign mb[r] = x8[r] ^ x2[r] ^ a[r];
        assign md[r] = x8[r] ^ x4[r] ^ a[r];
        assign me[r] = x8[r] ^ x4[r] ^ x2[r];
    end

    assign col_out[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign col_out[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    assign col_out[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    assign col_out[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for a state; accept registers state_in ^ round_key
// MIX   | replacing COLS_PER_CYCLE columns of work per cycle with InvMixColumns output
// DONE  | out_valid=1, state_out=work held until out_ready
module inv_addkey_mixcol_stage #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [3:0][31:0]  work;        // work[3] is column 0
    logic [1:0]        col_idx;
    logic              accept;
    logic [31:0]       mix_in  [COLS_PER_CYCLE];
    logic [31:0]       mix_out [COLS_PER_CYCLE];

    assign accept = in_valid && (state == IDLE);

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        logic [1:0] col_sel;
        assign col_sel   = col_idx + 2'(g);
        assign mix_in[g] = work[2'd3 - col_sel];
        mix_column_helper u_helper (
            .col_in  (mix_in[g]),
            .col_out (mix_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = last_round ? DONE : MIX;
            MIX:  if (col_idx == LAST_IDX) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        state_out = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE: begin
                out_valid = 1'b1;
                state_out = work;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            col_idx <= 2'd0;
        end else if (accept) begin
            work    <= state_in ^ round_key;
            col_idx <= 2'd0;
        end else if (state == MIX) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                work[2'd3 - (col_idx + 2'(g))] <= mix_out[g];
            end
            col_idx <= col_idx + STEP;
        end
    end
endmodule

// File: tb/tb_inv_addkey_mixcol_stage.sv
// Self-checking bench for inv_addkey_mixcol_stage at COLS_PER_CYCLE = 1, 2 and 4,
// against a byte-level GF(2^8) matrix model of AddRoundKey + InvMixColumns.
module tb_inv_addkey_mixcol_stage;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         last_round;
    logic         in_valid_v  [3];
    logic         out_ready_v [3];
    logic         in_ready_v  [3];
    logic         out_valid_v [3];
    logic         busy_v      [3];
    logic [127:0] state_out_v [3];

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

    always #5 clk = ~clk;

    inv_addkey_mixcol_stage #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .state_in(state_in), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .state_out(state_out_v[0]), .busy(busy_v[0]));
    inv_addkey_mixcol_stage #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .state_in(state_in), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .state_out(state_out_v[1]), .busy(busy_v[1]));
    inv_addkey_mixcol_stage #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .state_in(state_in), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .state_out(state_out_v[2]), .busy(busy_v[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic last);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] x = s ^ k;
        logic [127:0] r = '0;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        if (last) return x;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row) & 3], x[127 - 32*c - 8*j -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int lat_of(input int i, input bit last);
        if (last) return 1;
        return (i == 0) ? 5 : (i == 1) ? 3 : 2;
    endfunction

    // Drives one transfer into instance i with out_ready high; checks latency, data and return to IDLE.
    task automatic run_one(input int i, input logic [127:0] s, input logic [127:0] k,
                           input logic last, input logic [127:0] exp_out, input string name);
        int t;
        int lat;
        @(posedge clk); #1;
        state_in = s; round_key = k; last_round = last;
        in_valid_v[i] = 1'b1; out_ready_v[i] = 1'b1;
        t = 0;
        while (!in_ready_v[i] && t < 50) begin @(posedge clk); #1; t++; end
        n_cmp++;
        if (!in_ready_v[i]) begin
            n_err++; $display("FAIL %s_accept: in_ready stayed %b, required 1", name, in_ready_v[i]);
            in_valid_v[i] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid_v[i] = 1'b0;
        state_in = rnd128(); round_key = rnd128(); last_round = ~last;
        t = 0;
        while (!out_valid_v[i] && t < 20) begin @(posedge clk); #1; t++; end
        n_cmp++;
        if (!out_valid_v[i]) begin
            n_err++; $display("FAIL %s_timeout: out_valid never rose", name);
            return;
        end
        lat = t + 1;
        if (lat != lat_of(i, last)) begin
            n_err++; $display("FAIL %s_latency: got %0d, required %0d", name, lat, lat_of(i, last));
        end
        n_cmp++;
        if (state_out_v[i] !== exp_out) begin
            n_err++; $display("FAIL %s_data: got %h, required %h", name, state_out_v[i], exp_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid_v[i] !== 1'b0 || in_ready_v[i] !== 1'b1) begin
            n_err++; $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0/1",
                              name, out_valid_v[i], in_ready_v[i]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; state_in = '0; round_key = '0; last_round = 1'b0;
        for (int i = 0; i < 3; i++) begin in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 || busy_v[i] !== 1'b0 ||
                state_out_v[i] !== 128'h0) begin
                n_err++; $display("FAIL reset_%0d: in_ready=%b out_valid=%b busy=%b state_out=%h, required 1/0/0/0",
                                  i, in_ready_v[i], out_valid_v[i], busy_v[i], state_out_v[i]);
            end
        end
    endtask

    task automatic test_vectors();
        run_one(0, V1_IN, 128'h0, 1'b0, V1_OUT, "vec1_c1");
        run_one(0, 128'h00112233_44556677_8899aabb_ccddeeff, {128{1'b1}}, 1'b1,
                128'hffeeddcc_bbaa9988_77665544_33221100, "last_c1");
        for (int i = 0; i < 3; i++) begin
            run_one(i, V1_IN, V1_IN, 1'b0, 128'h0, $sformatf("zero_c%0d", i));
            run_one(i, V1_IN, 128'h0, 1'b0, V1_OUT, $sformatf("vec1_i%0d", i));
        end
    endtask

    task automatic test_random();
        logic [127:0] s, k;
        logic         l;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 4; n++) begin
                s = rnd128(); k = rnd128(); l = (n == 3);
                run_one(i, s, k, l, model(s, k, l), $sformatf("rand_i%0d_%0d", i, n));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s, k, e;
        int t;
        s = rnd128(); k = rnd128(); e = model(s, k, 1'b0);
        @(posedge clk); #1;
        state_in = s; round_key = k; last_round = 1'b0;
        in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        t = 0;
        while (!out_valid_v[0] && t < 20) begin @(posedge clk); #1; t++; end
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (out_valid_v[0] !== 1'b1 || state_out_v[0] !== e || in_ready_v[0] !== 1'b0 ||
                busy_v[0] !== 1'b1) begin
                n_err++; $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b busy=%b state_out=%h, required 1/0/1/%h",
                                  c, out_valid_v[0], in_ready_v[0], busy_v[0], state_out_v[0], e);
            end
            in_valid_v[0] = c[0];
            state_in = rnd128(); round_key = rnd128(); last_round = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        #1;
        n_cmp++;
        if (in_ready_v[0] !== 1'b0) begin
            n_err++; $display("FAIL bp_comb_path: in_ready=%b with out_ready just raised, required 0", in_ready_v[0]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
            n_err++; $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", in_ready_v[0], out_valid_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        state_in = V1_IN; round_key = rnd128(); last_round = 1'b0;
        in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 ||
            state_out_v[0] !== 128'h0) begin
            n_err++; $display("FAIL mid_reset: out_valid=%b in_ready=%b busy=%b state_out=%h, required 0/1/0/0",
                              out_valid_v[0], in_ready_v[0], busy_v[0], state_out_v[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_one(0, V1_IN, 128'h0, 1'b0, V1_OUT, "post_reset");
    endtask

    task automatic test_back_to_back();
        logic [127:0] vs [8];
        logic [127:0] vk [8];
        logic [127:0] exp_q [$];
        int sent, recv, cyc, last_out;
        for (int n = 0; n < 8; n++) begin vs[n] = rnd128(); vk[n] = rnd128(); end
        sent = 0; recv = 0; cyc = 0; last_out = 0;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b1; last_round = 1'b0;
        while (recv < 8 && cyc < 200) begin
            if (in_ready_v[0]) begin
                if (sent < 8) begin
                    state_in = vs[sent]; round_key = vk[sent]; in_valid_v[0] = 1'b1;
                    exp_q.push_back(model(vs[sent], vk[sent], 1'b0));
                    sent++;
                end else begin
                    in_valid_v[0] = 1'b0;
                end
            end
            if (out_valid_v[0]) begin
                n_cmp++;
                if (state_out_v[0] !== exp_q[recv]) begin
                    n_err++; $display("FAIL b2b_data_%0d: got %h, required %h", recv, state_out_v[0], exp_q[recv]);
                end
                if (recv > 0) begin
                    n_cmp++;
                    if (cyc - last_out != 6) begin
                        n_err++; $display("FAIL b2b_period_%0d: got %0d cycles, required 6", recv, cyc - last_out);
                    end
                end
                last_out = cyc;
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_v[0] = 1'b0;
        n_cmp++;
        if (recv != 8) begin
            n_err++; $display("FAIL b2b_count: got %0d outputs, required 8", recv);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
